// File: rtl/md_issue_pkg.sv
// Shared HiLoOp codes, MIPS SPECIAL decode constants and issue FSM states
// for the HI/LO multiply/divide issue path.
package md_issue_pkg;

  typedef enum logic [3:0] {
    NONE     = 4'd0,
    MULT_OP  = 4'd1,
    MULTU_OP = 4'd2,
    DIV_OP   = 4'd3,
    DIVU_OP  = 4'd4,
    MFHI_OP  = 4'd5,
    MFLO_OP  = 4'd6,
    MTHI_OP  = 4'd7,
    MTLO_OP  = 4'd8
  } hiloop_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } md_state_e;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  function automatic logic is_start_op(hiloop_e op);
    return (op == MULT_OP) || (op == MULTU_OP) || (op == DIV_OP) || (op == DIVU_OP);
  endfunction

endpackage

// File: rtl/md_issue_if.sv
// Issue-side link to multdiv: one-cycle HiLoOp command, its kill, and busy.
interface md_issue_if;
  import md_issue_pkg::*;

  // hiloop_ex != NONE is a one-cycle command; multdiv takes it at the clock
  // edge unless md_flush is high in that same cycle. md_busy high means a
  // multiply/divide is still running and HI/LO are not yet committed.
  hiloop_e hiloop_ex;
  logic    md_flush;
  logic    md_busy;

  modport master (output hiloop_ex, output md_flush, input md_busy);
  modport slave  (input hiloop_ex, input md_flush, output md_busy);
endinterface

// File: rtl/md_issue_decode.sv
// Combinational ID-stage decode of an instruction word into its HiLoOp code.
// Also used by the forwarding logic, so it carries no state.
module md_decode
  import md_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output hiloop_e     op,
  output logic        is_start,
  output logic        is_hilo
);

  logic unused_bits;
  assign unused_bits = ^instr[25:6];

  always_comb begin
    op = NONE;
    if (valid && instr[31:26] == OP_SPECIAL) begin
      case (instr[5:0])
        FUNCT_MULT:  op = MULT_OP;
        FUNCT_MULTU: op = MULTU_OP;
        FUNCT_DIV:   op = DIV_OP;
        FUNCT_DIVU:  op = DIVU_OP;
        FUNCT_MFHI:  op = MFHI_OP;
        FUNCT_MTHI:  op = MTHI_OP;
        FUNCT_MFLO:  op = MFLO_OP;
        FUNCT_MTLO:  op = MTLO_OP;
        default:     op = NONE;
      endcase
    end
  end

  assign is_start = is_start_op(op);
  assign is_hilo  = (op != NONE);

endmodule

// File: rtl/md_issue.sv
// EX-entry issue and hazard control for multdiv: registers HiLoOp into EX,
// stalls ID while a multiply/divide is outstanding, and counts stall cycles.
module md_issue
  import md_issue_pkg::*;
#(
  parameter int STALL_CNT_W = 16
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            id_instr,
  input  logic                   id_valid,
  input  logic                   id_hold,
  input  logic                   flush,
  md_issue_if.master             md,
  output logic                   stall_id,
  output logic                   md_pending,
  output logic                   md_err,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output md_state_e              state_dbg
);

  hiloop_e   id_op;
  logic      id_is_start;
  logic      id_is_hilo;
  hiloop_e   hiloop_q;
  hiloop_e   hiloop_d;
  md_state_e state_q;
  md_state_e state_d;
  logic      first_busy_q;
  logic      start_issue;
  logic      err_set;

  md_decode u_decode (
    .instr    (id_instr),
    .valid    (id_valid),
    .op       (id_op),
    .is_start (id_is_start),
    .is_hilo  (id_is_hilo)
  );

  assign stall_id    = id_is_hilo & (state_q != IDLE);
  assign start_issue = id_is_start & ~flush & ~id_hold & ~stall_id;
  assign md_pending  = (state_q != IDLE);
  assign state_dbg   = state_q;
  assign md.hiloop_ex = hiloop_q;
  // Only the op sitting in EX can be killed; a running unit is left alone.
  assign md.md_flush  = flush & (hiloop_q != NONE);

  always_comb begin
    hiloop_d = id_op;
    if (flush || stall_id || id_hold) hiloop_d = NONE;
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_issue) state_d = START;
        if (md.md_busy)  err_set = 1'b1;
      end
      START: state_d = flush ? IDLE : BUSY;
      BUSY: begin
        // Busy low on the very first BUSY cycle means multdiv never started.
        if (!md.md_busy) begin
          state_d = IDLE;
          err_set = first_busy_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      first_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_busy_q <= (state_q == START);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hiloop_q  <= NONE;
      md_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      hiloop_q <= hiloop_d;
      if (err_set) md_err <= 1'b1;
      if (stall_id && stall_cnt != {STALL_CNT_W{1'b1}})
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_md_issue.sv
// Bench for md_issue with a small behavioural multdiv on the slave side.
module tb_md_issue;
  import md_issue_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        id_hold;
  logic        flush;
  logic        stall_id;
  logic        md_pending;
  logic        md_err;
  logic [15:0] stall_cnt;
  md_state_e   state_dbg;

  md_issue_if mdif();

  md_issue #(.STALL_CNT_W(16)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .id_instr   (id_instr),
    .id_valid   (id_valid),
    .id_hold    (id_hold),
    .flush      (flush),
    .md         (mdif),
    .stall_id   (stall_id),
    .md_pending (md_pending),
    .md_err     (md_err),
    .stall_cnt  (stall_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- multdiv model ----------------
  // Busy lasts 4 cycles for MULT* and 9 for DIV*, giving dependent-op stalls
  // of 6 and 11 cycles through the issue FSM.
  logic [31:0] op_a, op_b;
  logic [31:0] mdl_hi, mdl_lo, res_hi, res_lo, mdl_c;
  int          mdl_cnt;
  logic        mdl_kill;

  function automatic logic [63:0] md_calc(hiloop_e op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      MULT_OP:  return sa * sb;
      MULTU_OP: return {32'h0, a} * {32'h0, b};
      DIV_OP:   return {$signed(a) % $signed(b), $signed(a) / $signed(b)};
      DIVU_OP:  return {a % b, a / b};
      default:  return 64'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_hi <= '0; mdl_lo <= '0; res_hi <= '0; res_lo <= '0; mdl_cnt <= 0;
    end else begin
      if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) begin
          mdl_hi <= res_hi;
          mdl_lo <= res_lo;
        end
      end
      if (!mdif.md_flush) begin
        case (mdif.hiloop_ex)
          MULT_OP, MULTU_OP, DIV_OP, DIVU_OP: begin
            {res_hi, res_lo} <= md_calc(mdif.hiloop_ex, op_a, op_b);
            if (mdl_kill) mdl_cnt <= 0;
            else mdl_cnt <= (mdif.hiloop_ex == MULT_OP || mdif.hiloop_ex == MULTU_OP) ? 4 : 9;
          end
          MTHI_OP: mdl_hi <= op_a;
          MTLO_OP: mdl_lo <= op_a;
          default: ;
        endcase
      end
    end
  end

  assign mdif.md_busy = (mdl_cnt != 0);
  assign mdl_c = (mdif.hiloop_ex == MFHI_OP) ? mdl_hi :
                 (mdif.hiloop_ex == MFLO_OP) ? mdl_lo : 32'h0;

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_exp;
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every op that reaches EX must be the next one expected, in order.
  always @(negedge clk) begin
    #2;
    if (mon_en && mdif.hiloop_ex != NONE) begin
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'(NONE);
      check("issue_order", 32'(mdif.hiloop_ex), 32'(mon_exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] instr, input logic v, input logic h, input logic f);
    @(negedge clk);
    id_instr = instr; id_valid = v; id_hold = h; flush = f;
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (md_pending && n < 40) begin
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check(name, 32'(md_pending), 32'h0);
  endtask

  // Start op in ID, then the dependent op held in ID until it stops stalling;
  // returns with the dependent op in EX.
  task automatic run_dep(input logic [31:0] start_instr, input logic [31:0] dep_instr,
                         output int stalls);
    drive(start_instr, 1'b1, 1'b0, 1'b0);
    stalls = 0;
    drive(dep_instr, 1'b1, 1'b0, 1'b0);
    while (stall_id && stalls < 40) begin
      stalls++;
      drive(dep_instr, 1'b1, 1'b0, 1'b0);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- decode vectors ----------------
  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        hold;
    hiloop_e     exp_op;
  } vec_t;

  vec_t vecs[13];

  localparam logic [31:0] I_MULT  = 32'h00851018;
  localparam logic [31:0] I_DIV   = 32'h0085001A;
  localparam logic [31:0] I_DIVU  = 32'h0085001B;
  localparam logic [31:0] I_MFHI  = 32'h00001010;
  localparam logic [31:0] I_MFLO  = 32'h00001012;
  localparam logic [31:0] I_MTHI  = 32'h00800011;
  localparam logic [31:0] I_ADDU  = 32'h00851021;

  initial begin
    int  stalls;
    logic any_stall;

    rst_n = 1'b0; id_instr = '0; id_valid = 1'b0; id_hold = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0; mdl_kill = 1'b0;

    vecs[0]  = '{32'h00851018, 1'b1, 1'b0, MULT_OP};
    vecs[1]  = '{32'h00000019, 1'b1, 1'b0, MULTU_OP};
    vecs[2]  = '{32'h0000001A, 1'b1, 1'b0, DIV_OP};
    vecs[3]  = '{32'h0000001B, 1'b1, 1'b0, DIVU_OP};
    vecs[4]  = '{32'h00000010, 1'b1, 1'b0, MFHI_OP};
    vecs[5]  = '{32'h00000011, 1'b1, 1'b0, MTHI_OP};
    vecs[6]  = '{32'h00000012, 1'b1, 1'b0, MFLO_OP};
    vecs[7]  = '{32'h00000013, 1'b1, 1'b0, MTLO_OP};
    vecs[8]  = '{32'h00851021, 1'b1, 1'b0, NONE};
    vecs[9]  = '{32'h04000018, 1'b1, 1'b0, NONE};
    vecs[10] = '{32'h00000018, 1'b0, 1'b0, NONE};
    vecs[11] = '{32'h00000018, 1'b1, 1'b1, NONE};
    vecs[12] = '{32'h8C000012, 1'b1, 1'b0, NONE};

    repeat (2) @(negedge clk);
    #1;
    check("rst_hiloop", 32'(mdif.hiloop_ex), 32'(NONE));
    check("rst_md_flush", 32'(mdif.md_flush), 32'h0);
    check("rst_stall_id", 32'(stall_id), 32'h0);
    check("rst_pending", 32'(md_pending), 32'h0);
    check("rst_err", 32'(md_err), 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Each vector issues for one cycle, then is flushed out of EX.
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].valid, vecs[i].hold, 1'b0);
      drive(32'h0, 1'b0, 1'b0, 1'b1);
      check("vec_op", 32'(mdif.hiloop_ex), 32'(vecs[i].exp_op));
      check("vec_flush", 32'(mdif.md_flush), 32'(vecs[i].exp_op != NONE));
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      check("vec_idle", 32'(md_pending), 32'h0);
    end

    mon_en = 1'b1;

    // MULT then dependent MFLO.
    op_a = 32'h00010003; op_b = 32'h00020005;
    exp_q.push_back(MULT_OP); exp_q.push_back(MFLO_OP);
    run_dep(I_MULT, I_MFLO, stalls);
    check("mult_stall_cycles", 32'(stalls), 32'd6);
    check("mflo_in_ex", 32'(mdif.hiloop_ex), 32'(MFLO_OP));
    check("mflo_result", mdl_c, 32'h000B000F);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("mflo_one_cycle", 32'(mdif.hiloop_ex), 32'(NONE));
    check("mult_stall_cnt", 32'(stall_cnt), 32'd6);
    check("mult_err", 32'(md_err), 32'h0);

    // DIVU then dependent MFHI.
    op_a = 32'd100; op_b = 32'd7;
    exp_q.push_back(DIVU_OP); exp_q.push_back(MFHI_OP);
    run_dep(I_DIVU, I_MFHI, stalls);
    check("divu_stall_cycles", 32'(stalls), 32'd11);
    check("mfhi_in_ex", 32'(mdif.hiloop_ex), 32'(MFHI_OP));
    check("divu_remainder", mdl_c, 32'd2);
    check("divu_stall_cnt", 32'(stall_cnt), 32'd17);

    // DIVU followed by independent ALU work.
    exp_q.push_back(DIVU_OP);
    drive(I_DIVU, 1'b1, 1'b0, 1'b0);
    any_stall = 1'b0;
    repeat (12) begin
      drive(I_ADDU, 1'b1, 1'b0, 1'b0);
      any_stall |= stall_id;
    end
    check("addu_no_stall", 32'(any_stall), 32'h0);
    wait_idle("addu_idle");
    check("addu_stall_cnt", 32'(stall_cnt), 32'd17);

    // MULT killed in EX.
    op_a = 32'd3; op_b = 32'd5;
    exp_q.push_back(MULT_OP);
    drive(I_MULT, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b1);
    check("kill_md_flush", 32'(mdif.md_flush), 32'h1);
    check("kill_pending_start", 32'(md_pending), 32'h1);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("kill_pending", 32'(md_pending), 32'h0);
    check("kill_busy", 32'(mdif.md_busy), 32'h0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("kill_busy_later", 32'(mdif.md_busy), 32'h0);
    check("kill_err", 32'(md_err), 32'h0);

    // Flush while BUSY, with a stalled MFHI in ID: flush wins, MULT completes.
    exp_q.push_back(MULT_OP); exp_q.push_back(MFLO_OP);
    drive(I_MULT, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    drive(I_MFHI, 1'b1, 1'b0, 1'b1);
    check("busyflush_md_flush", 32'(mdif.md_flush), 32'h0);
    check("busyflush_stall", 32'(stall_id), 32'h1);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("busyflush_no_issue", 32'(mdif.hiloop_ex), 32'(NONE));
    check("busyflush_pending", 32'(md_pending), 32'h1);
    wait_idle("busyflush_idle");
    drive(I_MFLO, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("busyflush_mflo", 32'(mdif.hiloop_ex), 32'(MFLO_OP));
    check("busyflush_result", mdl_c, 32'd15);
    check("busyflush_stall_cnt", 32'(stall_cnt), 32'd18);

    // Asynchronous reset during DIV BUSY.
    op_a = 32'd50; op_b = 32'd3;
    exp_q.push_back(DIV_OP);
    drive(I_DIV, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    drive(I_MFHI, 1'b1, 1'b0, 1'b0);
    check("div_busy_stall", 32'(stall_id), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_hiloop", 32'(mdif.hiloop_ex), 32'(NONE));
    check("arst_pending", 32'(md_pending), 32'h0);
    check("arst_stall_id", 32'(stall_id), 32'h0);
    check("arst_stall_cnt", 32'(stall_cnt), 32'h0);
    check("arst_state", 32'(state_dbg), 32'(IDLE));
    id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op_a = 32'h00001234;
    exp_q.push_back(MTHI_OP); exp_q.push_back(MFHI_OP);
    drive(I_MTHI, 1'b1, 1'b0, 1'b0);
    check("mthi_no_stall", 32'(stall_id), 32'h0);
    drive(I_MFHI, 1'b1, 1'b0, 1'b0);
    check("mfhi_after_mthi_no_stall", 32'(stall_id), 32'h0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("mthi_readback", mdl_c, 32'h00001234);

    // multdiv never goes busy after a start.
    exp_q.push_back(MULT_OP);
    mdl_kill = 1'b1;
    drive(I_MULT, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("noerr_before", 32'(md_err), 32'h0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("err_set", 32'(md_err), 32'h1);
    check("err_idle", 32'(md_pending), 32'h0);
    mdl_kill = 1'b0;
    repeat (3) drive(32'h0, 1'b0, 1'b0, 1'b0);
    check("err_sticky", 32'(md_err), 32'h1);
    rst_n = 1'b0;
    #1;
    check("err_cleared", 32'(md_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
